// File: rtl/vrisc_core.sv
// VeriRISC accumulator core: 3-bit opcode, one state per phase, wait-state
// capable memory port and single-step pause.
module vrisc_core #(
    parameter int DATA_W = 8,   // must be >= ADDR_W+3
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              step_en,
    input  logic              step_req,
    output logic              fetch,
    output logic              load_ir,
    output logic              retire,
    output logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] accum,
    output logic [2:0]        opcode,
    output logic              zero,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_IFETCH, S_DECODE, S_OPRD, S_OPWR, S_PAUSE, S_HALT
    } state_t;

    localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3,
                           OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

    state_t              state, nstate, after_st;
    logic [DATA_W-1:0]   ir, acc_nxt;
    logic [ADDR_W-1:0]   pc_nxt, operand;

    assign opcode    = ir[DATA_W-1 -: 3];
    assign operand   = ir[ADDR_W-1:0];
    assign zero      = (accum == '0);
    assign mem_wdata = accum;
    assign after_st  = step_en ? S_PAUSE : S_IFETCH;

    always_comb begin
        nstate   = state;
        pc_nxt   = pc;
        acc_nxt  = accum;
        mem_addr = pc;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        fetch    = 1'b0;
        load_ir  = 1'b0;
        retire   = 1'b0;
        halt     = 1'b0;
        case (state)
            S_IDLE: nstate = S_IFETCH;
            S_IFETCH: begin
                mem_rd = 1'b1;
                fetch  = 1'b1;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    nstate  = S_DECODE;
                end
            end
            S_DECODE: begin
                pc_nxt = pc + ADDR_W'(1);
                case (opcode)
                    OP_HLT: begin
                        pc_nxt = pc;
                        nstate = S_HALT;
                    end
                    OP_SKZ: begin
                        if (zero) pc_nxt = pc + ADDR_W'(2);
                        retire = 1'b1;
                        nstate = after_st;
                    end
                    OP_JMP: begin
                        pc_nxt = operand;
                        retire = 1'b1;
                        nstate = after_st;
                    end
                    OP_STO:  nstate = S_OPWR;
                    default: nstate = S_OPRD;
                endcase
            end
            S_OPRD: begin
                mem_addr = operand;
                mem_rd   = 1'b1;
                if (mem_ready) begin
                    case (opcode)
                        OP_ADD:  acc_nxt = accum + mem_rdata;
                        OP_AND:  acc_nxt = accum & mem_rdata;
                        OP_XOR:  acc_nxt = accum ^ mem_rdata;
                        default: acc_nxt = mem_rdata;
                    endcase
                    retire = 1'b1;
                    nstate = after_st;
                end
            end
            S_OPWR: begin
                mem_addr = operand;
                mem_wr   = 1'b1;
                if (mem_ready) begin
                    retire = 1'b1;
                    nstate = after_st;
                end
            end
            // step_req only matters here, so pulses elsewhere are simply lost
            S_PAUSE: if (step_req || !step_en) nstate = S_IFETCH;
            S_HALT:  halt = 1'b1;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= S_IDLE;
            pc         <= '0;
            accum      <= '0;
            ir         <= '0;
            retire_cnt <= '0;
        end else begin
            state <= nstate;
            pc    <= pc_nxt;
            accum <= acc_nxt;
            if (load_ir) ir <= mem_rdata;
            if (retire)  retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vrisc_core.sv
// Directed bench for vrisc_core: default 8/5 core plus a 12/8 core, each
// with its own wait-state memory model.
module tb_vrisc_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- core A: DATA_W=8, ADDR_W=5 ----------------
    logic        rst_a = 1'b0;
    logic [4:0]  a_addr, a_pc;
    logic        a_rd, a_wr, a_ready, a_fetch, a_load_ir, a_retire, a_halt, a_zero;
    logic [7:0]  a_wdata, a_rdata, a_accum;
    logic [2:0]  a_opcode;
    logic [15:0] a_cnt;
    logic        a_step_en = 1'b0, a_step_req = 1'b0;

    vrisc_core u_a (
        .clk(clk), .rst_(rst_a), .mem_addr(a_addr), .mem_rd(a_rd), .mem_wr(a_wr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ready(a_ready),
        .step_en(a_step_en), .step_req(a_step_req), .fetch(a_fetch), .load_ir(a_load_ir),
        .retire(a_retire), .halt(a_halt), .pc(a_pc), .accum(a_accum), .opcode(a_opcode),
        .zero(a_zero), .retire_cnt(a_cnt)
    );

    logic [7:0] mem_a [32];
    int         wait_a = 0;
    int         wcnt_a = 0;
    logic [4:0] flog [$];
    logic [4:0] hold_addr;
    logic [7:0] hold_wd;
    logic       hold_v = 1'b0;
    int         stab_err = 0;

    assign a_ready = (a_rd || a_wr) && (wcnt_a >= wait_a);
    assign a_rdata = mem_a[a_addr];

    always @(posedge clk) begin
        if (a_rd && a_wr) stab_err++;
        if (hold_v && (a_rd || a_wr) && (a_addr !== hold_addr || (a_wr && a_wdata !== hold_wd)))
            stab_err++;
        hold_v    = (a_rd || a_wr) && !a_ready;
        hold_addr = a_addr;
        hold_wd   = a_wdata;
        if (a_rd || a_wr) begin
            if (a_ready) begin
                wcnt_a <= 0;
                if (a_wr) mem_a[a_addr] <= a_wdata;
                if (a_fetch) flog.push_back(a_addr);
            end else begin
                wcnt_a <= wcnt_a + 1;
            end
        end else begin
            wcnt_a <= 0;
        end
    end

    // ---------------- core B: DATA_W=12, ADDR_W=8 ----------------
    logic        rst_b = 1'b0;
    logic [7:0]  b_addr, b_pc;
    logic        b_rd, b_wr, b_ready, b_fetch, b_load_ir, b_retire, b_halt, b_zero;
    logic [11:0] b_wdata, b_rdata, b_accum;
    logic [2:0]  b_opcode;
    logic [15:0] b_cnt;
    logic        b_step_en = 1'b0, b_step_req = 1'b0;

    vrisc_core #(.DATA_W(12), .ADDR_W(8)) u_b (
        .clk(clk), .rst_(rst_b), .mem_addr(b_addr), .mem_rd(b_rd), .mem_wr(b_wr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ready(b_ready),
        .step_en(b_step_en), .step_req(b_step_req), .fetch(b_fetch), .load_ir(b_load_ir),
        .retire(b_retire), .halt(b_halt), .pc(b_pc), .accum(b_accum), .opcode(b_opcode),
        .zero(b_zero), .retire_cnt(b_cnt)
    );

    logic [11:0] mem_b [256];
    int          wait_b = 3;
    int          wcnt_b = 0;

    assign b_ready = (b_rd || b_wr) && (wcnt_b >= wait_b);
    assign b_rdata = mem_b[b_addr];

    always @(posedge clk) begin
        if (b_rd || b_wr) begin
            if (b_ready) begin
                wcnt_b <= 0;
                if (b_wr) mem_b[b_addr] <= b_wdata;
            end else begin
                wcnt_b <= wcnt_b + 1;
            end
        end else begin
            wcnt_b <= 0;
        end
    end

    // ---------------- helpers ----------------
    task automatic reset_a(input int w, input logic se);
        @(negedge clk);
        rst_a      = 1'b0;
        wait_a     = w;
        a_step_en  = se;
        a_step_req = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 32; i++) mem_a[i] = 8'h00;
        flog.delete();
        stab_err = 0;
    endtask

    task automatic load_main;
        mem_a[0]     = 8'hBE;  // LDA 1E
        mem_a[1]     = 8'h5F;  // ADD 1F
        mem_a[2]     = 8'hDD;  // STO 1D
        mem_a[3]     = 8'h00;  // HLT
        mem_a[5'h1E] = 8'h7F;
        mem_a[5'h1F] = 8'h85;
        mem_a[5'h1D] = 8'hEE;
    endtask

    // called right after release of reset at a negedge; counts edges to halt
    task automatic run_to_halt(output int n);
        n = 0;
        while (!a_halt && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_cnt_a(input int k);
        for (int i = 0; i < 60 && a_cnt != 16'(k); i++) @(negedge clk);
    endtask

    int         n;
    logic [4:0] exp_skz [10];

    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = 12'h000;

        // reset state
        reset_a(0, 1'b0);
        chk("rst_pc", a_pc, 0);
        chk("rst_accum", a_accum, 0);
        chk("rst_opcode", a_opcode, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_zero", a_zero, 1);
        chk("rst_strobes", {a_rd, a_wr, a_fetch, a_load_ir, a_retire, a_halt}, 6'b0);

        // main program, zero wait states
        load_main();
        rst_a = 1'b1;
        #1 chk("idle_no_fetch", {a_rd, a_fetch}, 2'b00);
        run_to_halt(n);
        chk("main_cycles", n, 12);
        chk("main_store", mem_a[5'h1D], 8'h04);
        chk("main_halt", a_halt, 1);
        chk("main_cnt", a_cnt, 3);
        chk("main_pc", a_pc, 3);
        chk("main_accum", a_accum, 8'h04);
        chk("main_zero", a_zero, 0);
        chk("main_nreq", {a_rd, a_wr}, 2'b00);
        chk("main_fetches", flog.size(), 4);

        // same program, two wait cycles per access
        reset_a(2, 1'b0);
        load_main();
        rst_a = 1'b1;
        run_to_halt(n);
        chk("ws_cycles", n, 26);
        chk("ws_store", mem_a[5'h1D], 8'h04);
        chk("ws_cnt", a_cnt, 3);
        chk("ws_pc", a_pc, 3);
        chk("ws_stable", stab_err, 0);

        // SKZ both ways, and wrap from pc=30
        reset_a(0, 1'b0);
        mem_a[0]     = 8'hE4;  // JMP 4
        mem_a[4]     = 8'h20;  // SKZ
        mem_a[5]     = 8'hE8;  // JMP 8
        mem_a[6]     = 8'hBC;  // LDA 1C
        mem_a[7]     = 8'hE4;  // JMP 4
        mem_a[8]     = 8'hBB;  // LDA 1B
        mem_a[9]     = 8'hFE;  // JMP 1E
        mem_a[5'h1E] = 8'h20;  // SKZ
        mem_a[5'h1B] = 8'h00;
        mem_a[5'h1C] = 8'h01;
        exp_skz = '{5'd0, 5'd4, 5'd6, 5'd7, 5'd4, 5'd5, 5'd8, 5'd9, 5'h1E, 5'd0};
        rst_a = 1'b1;
        for (int i = 0; i < 200 && flog.size() < 10; i++) @(negedge clk);
        chk("skz_nfetch", (flog.size() >= 10) ? 1 : 0, 1);
        for (int i = 0; i < 10 && i < flog.size(); i++)
            chk($sformatf("skz_fetch%0d", i), flog[i], exp_skz[i]);

        // JMP then HLT at target
        reset_a(0, 1'b0);
        mem_a[0]     = 8'hF0;  // JMP 10
        mem_a[5'h10] = 8'h00;  // HLT
        rst_a = 1'b1;
        run_to_halt(n);
        chk("jmp_cycles", n, 5);
        chk("jmp_nfetch", flog.size(), 2);
        if (flog.size() == 2) begin
            chk("jmp_fetch0", flog[0], 5'h00);
            chk("jmp_fetch1", flog[1], 5'h10);
        end
        chk("jmp_pc", a_pc, 5'h10);
        chk("jmp_halt", a_halt, 1);
        chk("jmp_cnt", a_cnt, 1);

        // single-step: pause after each retire, stray step_req in IFETCH ignored
        reset_a(0, 1'b1);
        load_main();
        rst_a = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_cnt_a(k);
            repeat (4) @(negedge clk);
            chk($sformatf("step_cnt%0d", k), a_cnt, k);
            chk($sformatf("step_nreq%0d", k), {a_rd, a_wr, a_halt}, 3'b000);
            a_step_req = 1'b1;
            @(negedge clk);
            a_step_req = 1'b1;  // now in IFETCH
            @(negedge clk);
            a_step_req = 1'b0;
        end
        repeat (4) @(negedge clk);
        chk("step_halt", a_halt, 1);
        chk("step_cnt_end", a_cnt, 3);
        chk("step_store", mem_a[5'h1D], 8'h04);

        // wide core: XOR, then reset in the middle of a waiting store
        rst_b = 1'b0;
        mem_b[0]     = 12'hA81;  // LDA 81
        mem_b[1]     = 12'h880;  // XOR 80
        mem_b[2]     = 12'hC82;  // STO 82
        mem_b[3]     = 12'h000;  // HLT
        mem_b[8'h80] = 12'hAAA;
        mem_b[8'h81] = 12'hFFF;
        mem_b[8'h82] = 12'h123;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 100 && b_cnt != 16'd2; i++) @(negedge clk);
        chk("b_cnt2", b_cnt, 2);
        chk("b_xor", b_accum, 12'h555);
        for (int i = 0; i < 100 && !b_wr; i++) @(negedge clk);
        chk("b_opwr", {b_wr, b_addr, b_wdata}, {1'b1, 8'h82, 12'h555});
        #1 rst_b = 1'b0;
        #1;
        chk("b_rst_req", {b_rd, b_wr, b_fetch, b_load_ir, b_retire, b_halt}, 6'b0);
        chk("b_rst_state", {b_pc, b_accum, b_opcode, b_zero}, {8'h00, 12'h000, 3'd0, 1'b1});
        chk("b_rst_cnt", b_cnt, 0);
        repeat (3) @(posedge clk);
        #1 chk("b_no_write", mem_b[8'h82], 12'h123);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vrisc_core.md
# vrisc_core

Parametrised VeriRISC execution core: 3-bit opcode accumulator machine (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) with a single-cycle-per-phase controller, an external wait-state-capable memory port and a single-step debug mode. It replaces the fixed 8-bit/5-bit CPU with its fixed eight-phase sequencer. The core sits between the system memory (or its arbiter) and the debug/test harness, which observes `halt`, `fetch`, `load_ir`, `retire` and the architectural state.

## Interface
- DATA_W, 8, word width of accumulator, memory data and instruction; requires DATA_W >= ADDR_W+3
- ADDR_W, 5, memory address width; operand = instruction[ADDR_W-1:0], opcode = instruction[DATA_W-1:DATA_W-3]
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock; all state changes on rising edge
- rst_  in  1  reset, asynchronous, active-low
- mem_addr  out  ADDR_W  memory address
- mem_rd / mem_wr  out  1  read / write request, held until mem_ready
- mem_wdata  out  DATA_W  write data (= accum)
- mem_rdata  in  DATA_W  read data, valid when mem_ready=1 during mem_rd
- mem_ready  in  1  completes current access on the edge where sampled high
- step_en  in  1  single-step mode enable
- step_req  in  1  one-cycle pulse: execute one instruction while paused
- fetch / load_ir / retire / halt  out  1  status strobes (see Operation)
- pc  out  ADDR_W; accum  out  DATA_W; opcode  out  3; zero  out  1 (accum == 0)
- retire_cnt  out  CNT_W  instructions retired since reset

## Operation
- States: IDLE, IFETCH, DECODE, OPRD, OPWR, PAUSE, HALT. Reset state IDLE; IDLE -> IFETCH unconditionally.
- IFETCH: mem_addr=pc, mem_rd=1, fetch=1. Stay while mem_ready=0. On mem_ready=1: ir <= mem_rdata, load_ir=1 that cycle, -> DECODE.
- DECODE: pc <= pc+1 (mod 2^ADDR_W), then per opcode:
  - HLT (0): pc not incremented, -> HALT.
  - SKZ (1): pc <= pc+2 if accum==0, else pc+1; retire; -> next.
  - JMP (7): pc <= operand; retire; -> next.
  - ADD(2)/AND(3)/XOR(4)/LDA(5): -> OPRD. STO (6): -> OPWR.
- OPRD: mem_addr=operand, mem_rd=1; on mem_ready: accum <= accum+rdata (wraps mod 2^DATA_W, carry discarded) / accum&rdata / accum^rdata / rdata; retire; -> next.
- OPWR: mem_addr=operand, mem_wr=1, mem_wdata=accum; on mem_ready: retire; -> next.
- "next" = PAUSE if step_en=1, else IFETCH.
- PAUSE: no memory request. step_req=1 or step_en=0 -> IFETCH.
- HALT: halt=1, no requests; exits only via rst_.
- retire: one-cycle pulse on completing cycle; retire_cnt += 1, wraps. HLT does not retire.
- mem_rd and mem_wr never both high; mem_addr/mem_wdata stable while a request waits.
- Reset values: pc=0, accum=0, ir=0 (opcode=0), retire_cnt=0, all strobes and requests 0, zero=1.

## Timing
- All outputs registered or decoded from state; mem_rd/fetch high from the first edge after rst_ release plus one (IDLE cycle).
- Zero wait states: SKZ/JMP = 2 cycles, ALU/LDA/STO = 3 cycles, IFETCH-to-IFETCH. Each low mem_ready cycle adds one.
- accum, pc update visible the cycle after the retire edge.
- step_req outside PAUSE is ignored (not stored); step_req in the same cycle as entering PAUSE is ignored.
- rst_ asserted mid-access: requests drop immediately (asynchronous), any pending write is abandoned.
- pc wraps from 2^ADDR_W-1 to 0; SKZ at pc=2^ADDR_W-2 with accum=0 yields pc=0.

## Test plan
- Defaults, mem_ready=1, program {LDA 0x1E; ADD 0x1F; STO 0x1D; HLT}, mem[1E]=0x7F, mem[1F]=0x85 -> mem[1D]=0x04, halt=1, retire_cnt=3, pc=3, 3+3+3+2 cycles to halt.
- mem_ready low 2 cycles on every access, same program -> identical results, each access +2 cycles, addresses held stable.
- SKZ with accum=0 at pc=4 -> next fetch address 6; with accum=0x01 -> 5; SKZ at pc=30 with accum=0 -> pc=0.
- JMP 0x10 then HLT at 0x10 -> fetch addresses 0,0x10; halt with pc=0x10.
- step_en=1: core sits in PAUSE after each retire; step_req pulses advance exactly one instruction each; step_req during IFETCH has no effect.
- DATA_W=12, ADDR_W=8: XOR 0x80 with accum=0xFFF, mem[0x80]=0xAAA -> accum=0x555; rst_ asserted mid-OPWR -> no write, all outputs at reset values.
